// File: rtl/log_dispatch.sv
// log_dispatch: FIFO-buffered issue stage for the 64-bit logic unit with tagged result return
module log_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [63:0]     in_opa,
  input  logic [63:0]     in_opb,
  input  logic [TAGW-1:0] in_tag,
  output logic            lu_en,
  output logic [2:0]      lu_operation,
  output logic [63:0]     lu_opa,
  output logic [63:0]     lu_opb,
  input  logic [63:0]     lu_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [63:0]     res_data,
  output logic [TAGW-1:0] res_tag,
  output logic            res_err,
  output logic [CNTW-1:0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] OP_ILL = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t          state_q;
  logic [2:0]      op_mem_q  [DEPTH];
  logic [63:0]     opa_mem_q [DEPTH];
  logic [63:0]     opb_mem_q [DEPTH];
  logic [TAGW-1:0] tag_mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            ill_q;
  logic [TAGW-1:0] tag_q;
  logic            res_valid_q, res_err_q;
  logic [63:0]     res_data_q;
  logic [TAGW-1:0] res_tag_q;
  logic            empty, push, pop;
  logic [TAGW-1:0] head_tag;
  // Head view, handshakes and issue decision; the head reads as zeros when the FIFO is empty
  always_comb begin
    empty        = count_q == '0;
    in_ready     = count_q != CNTW'(DEPTH);
    push         = in_valid && in_ready;
    pop          = !empty && (state_q == IDLE || (state_q == HOLD && res_ready));
    lu_operation = empty ? 3'b000 : op_mem_q[rd_ptr_q];
    lu_opa       = empty ? 64'd0 : opa_mem_q[rd_ptr_q];
    lu_opb       = empty ? 64'd0 : opb_mem_q[rd_ptr_q];
    head_tag     = empty ? '0 : tag_mem_q[rd_ptr_q];
    lu_en        = pop && lu_operation != OP_ILL;
    count_d      = count_q + CNTW'(push) - CNTW'(pop);
  end
  // Entry storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q]  <= in_op;
      opa_mem_q[wr_ptr_q] <= in_opa;
      opb_mem_q[wr_ptr_q] <= in_opb;
      tag_mem_q[wr_ptr_q] <= in_tag;
    end
  end
  // FIFO pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q  <= count_d;
    end
  end
  // Issue/result FSM: one request outstanding, result captured from the unit in WAIT and held until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ill_q       <= 1'b0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= 64'd0;
      res_tag_q   <= '0;
    end else begin
      if (pop) begin
        ill_q <= lu_operation == OP_ILL;
        tag_q <= head_tag;
      end
      if (state_q == WAIT) begin
        res_data_q <= ill_q ? 64'd0 : lu_out;
        res_err_q  <= ill_q;
        res_tag_q  <= tag_q;
      end
      res_valid_q <= state_q == WAIT ? 1'b1 : (state_q == HOLD && res_ready) ? 1'b0 : res_valid_q;
      state_q     <= pop ? WAIT : state_q == WAIT ? HOLD : (state_q == HOLD && res_ready) ? IDLE : state_q;
    end
  end
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_log_dispatch.sv
// tb_log_dispatch: scoreboard bench for log_dispatch with a behavioural logic unit
module tb_log_dispatch;
  localparam logic [63:0] A = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] B = 64'h0F0F0F0F0F0F0F0F;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_opa, in_opb;
  logic [3:0]  in_tag;
  logic        lu_en;
  logic [2:0]  lu_operation;
  logic [63:0] lu_opa, lu_opb, lu_out;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;
  logic [2:0]  fifo_count;
  typedef struct packed {logic [63:0] d; logic [3:0] t; logic e;} exp_t;
  exp_t        q[$];
  exp_t        e;
  int          cmp = 0, bad = 0, cyc = 0, last_res = 0;
  bit          gap_chk = 0, have_prev = 0;
  logic [63:0] exp_d;
  logic        exp_e;
  logic [2:0]  s_op [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4};
  logic [63:0] s_exp [9] = '{64'h0F0F00000F0F0000, 64'hF0F0FFFFF0F0FFFF, 64'hFFFF0F0FFFFF0F0F,
                             64'h0000F0F00000F0F0, 64'hF0F00F0FF0F00F0F, 64'h0F0FF0F00F0FF0F0,
                             64'h0000FFFF0000FFFF, 64'h0000000000000000, 64'hFEDCBA9876543210};

  log_dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_opa(in_opa), .in_opb(in_opb), .in_tag(in_tag), .lu_en(lu_en),
    .lu_operation(lu_operation), .lu_opa(lu_opa), .lu_opb(lu_opb), .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_err(res_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (lu_en)
      case (lu_operation)
        3'd0: lu_out <= lu_opa & lu_opb;
        3'd1: lu_out <= ~(lu_opa & lu_opb);
        3'd2: lu_out <= lu_opa | lu_opb;
        3'd3: lu_out <= ~(lu_opa | lu_opb);
        3'd4: lu_out <= lu_opa ^ lu_opb;
        3'd5: lu_out <= ~(lu_opa ^ lu_opb);
        3'd6: lu_out <= ~lu_opa;
        default: lu_out <= 64'hDEADBEEFDEADBEEF;
      endcase

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    cmp++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      have_prev = 0;
    end else begin
      if (in_valid && in_ready) q.push_back({exp_d, in_tag, exp_e});
      if (lu_en) check("lu_en_on_illegal", 64'(lu_operation == 3'b111), 64'd0);
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL res_unexpected: got tag %0d want no result", res_tag);
        end else begin
          e = q.pop_front();
          check("res_data", res_data, e.d);
          check("res_tag", 64'(res_tag), 64'(e.t));
          check("res_err", 64'(res_err), 64'(e.e));
        end
        if (gap_chk && have_prev) check("res_gap", 64'(cyc - last_res), 64'd2);
        have_prev = 1;
        last_res = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag, input logic [63:0] ed, input logic ee);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_opa = a; in_opb = b; in_tag = tag; exp_d = ed; exp_e = ee;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      cmp++;
      bad++;
      $display("FAIL push_timeout tag %0d: in_ready 0 want 1", tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || res_valid) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_opa = '0; in_opb = '0; in_tag = '0;
    res_ready = 1'b0; exp_d = '0; exp_e = 1'b0;
    tick(); tick();
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_lu_en", 64'(lu_en), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);
    // single AND with cycle-exact latency
    res_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_opa = A; in_opb = B; in_tag = 4'd5;
    exp_d = 64'h0F0F00000F0F0000; exp_e = 1'b0;
    tick();
    in_valid = 1'b0;
    check("and_c1_lu_en", 64'(lu_en), 64'd1);
    check("and_c1_lu_opa", lu_opa, A);
    check("and_c1_lu_opb", lu_opb, B);
    tick();
    check("and_c2_lu_en", 64'(lu_en), 64'd0);
    check("and_c2_res_valid", 64'(res_valid), 64'd0);
    tick();
    check("and_c3_res_valid", 64'(res_valid), 64'd1);
    check("and_c3_res_data", res_data, 64'h0F0F00000F0F0000);
    drain("and");
    // illegal opcode
    in_valid = 1'b1; in_op = 3'd7; in_opa = A; in_opb = B; in_tag = 4'd9; exp_d = 64'd0; exp_e = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ill_c1_lu_en", 64'(lu_en), 64'd0);
    tick(); tick();
    check("ill_c3_res_valid", 64'(res_valid), 64'd1);
    check("ill_c3_res_err", 64'(res_err), 64'd1);
    drain("ill");
    // full FIFO under backpressure
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(3'd2, 64'(i + 1), 64'(i + 1) << 32, 4'(i + 1), {32'(i + 1), 32'(i + 1)}, 1'b0);
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_op = 3'd0; in_opa = A; in_opb = B; in_tag = 4'd6; exp_d = 64'd0; exp_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_reject_ready", 64'(in_ready), 64'd0);
      check("full_reject_count", 64'(fifo_count), 64'd4);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    drain("full");
    // long backpressure in HOLD
    res_ready = 1'b0;
    push(3'd0, A, B, 4'd3, 64'h0F0F00000F0F0000, 1'b0);
    push(3'd4, A, B, 4'd4, 64'hF0F00F0FF0F00F0F, 1'b0);
    for (int n = 0; n < 20 && !res_valid; n++) tick();
    check("bp_res_valid", 64'(res_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_data", res_data, 64'h0F0F00000F0F0000);
      check("bp_hold_tag", 64'(res_tag), 64'd3);
      check("bp_hold_err", 64'(res_err), 64'd0);
      check("bp_hold_lu_en", 64'(lu_en), 64'd0);
      check("bp_hold_count", 64'(fifo_count), 64'd1);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_lu_en", 64'(lu_en), 64'd1);
    check("bp_release_op", 64'(lu_operation), 64'd4);
    drain("bp");
    // reset while WAIT with three entries queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(3'd2, 64'(i + 1), 64'(i + 1) << 32, 4'(i + 10), {32'(i + 1), 32'(i + 1)}, 1'b0);
    check("mid_hold_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("mid_wait_count", 64'(fifo_count), 64'd3);
    check("mid_wait_lu_en", 64'(lu_en), 64'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_lu_en", 64'(lu_en), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_res_valid", 64'(res_valid), 64'd0);
      check("post_rst_lu_en", 64'(lu_en), 64'd0);
    end
    res_ready = 1'b1;
    push(3'd0, A, B, 4'd7, 64'h0F0F00000F0F0000, 1'b0);
    drain("post_rst");
    // streaming, one result every two cycles
    gap_chk = 1; have_prev = 0;
    for (int i = 0; i < 9; i++)
      push(s_op[i], i == 8 ? 64'h0123456789ABCDEF : A, i == 8 ? 64'hFFFFFFFFFFFFFFFF : B,
           4'(i + 1), s_exp[i], s_op[i] == 3'd7);
    drain("stream");
    gap_chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
